// File: rtl/convex_dispatch.sv
// convex_dispatch: upstream feeder for the convex-hull engine.
//
// Points arrive as back-to-back bursts, are buffered in a DEPTH-entry FIFO
// and are issued to the hull engine one at a time. After each issue the
// dispatcher waits for the engine's full response burst before it issues
// the next point. Per-pattern completion is reported with pat_done.
//
// Optional feature: define CONVEX_DISPATCH_STATS_EN to build a per-pattern
// drop accumulator that drives pat_drops. Without it, pat_drops is tied to 0.
//
// Handshake: an upstream point transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the registered FIFO count,
// never on in_valid. The engine side has no back-pressure: cv_in_valid is a
// one-cycle issue pulse, and cv_out_valid is accepted only while a point is
// outstanding.
//
// Debug outputs: dbg_state (FSM state), dbg_count (FIFO occupancy) and
// dbg_drop (last sampled engine drop count).

module convex_dispatch #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8:0]             pt_num,
    input  logic [9:0]             in_x,
    input  logic [9:0]             in_y,
    output logic                   cv_in_valid,
    output logic [8:0]             cv_pt_num,
    output logic [9:0]             cv_in_x,
    output logic [9:0]             cv_in_y,
    input  logic                   cv_out_valid,
    input  logic [6:0]             cv_drop_num,
    output logic                   pat_done,
    output logic                   pat_err,
    output logic [8:0]             pat_drops,
    output logic [1:0]             dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count,
    output logic [6:0]             dbg_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Shortest and longest pattern the engine can take.
    localparam logic [8:0] MIN_LEN = 9'd4;
    localparam logic [8:0] MAX_LEN = 9'd500;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;

    logic [28:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic [8:0]    in_len_q;
    logic [8:0]    in_cnt_q;
    logic          discard_q;
    logic          pat_err_q;

    logic          push;
    logic          pat_start;
    logic          len_illegal;
    logic          drop_point;
    logic          wr_en;
    logic [28:0]   wr_data;

    logic          pop;
    logic          drop_sample;
    logic          drain_exit;
    logic          pat_done_d;

    logic [8:0]    cv_pt_num_q;
    logic [9:0]    cv_in_x_q;
    logic [9:0]    cv_in_y_q;
    logic [8:0]    out_cnt_q;
    logic          pat_done_q;
    logic [6:0]    drop_q;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    assign in_ready = (count_q < FULL_COUNT);

    // Classify each push: pattern start, legality, and whether it is stored.
    always_comb begin
        push        = in_valid && in_ready;
        pat_start   = (in_cnt_q == in_len_q);
        len_illegal = (pt_num < MIN_LEN) || (pt_num > MAX_LEN);
        drop_point  = pat_start ? len_illegal : discard_q;
        wr_en       = push && !drop_point;
        // Later points of a pattern carry the length latched at its start.
        wr_data     = {(pat_start ? pt_num : in_len_q), in_x, in_y};
    end

    // Track position within the incoming pattern and flag illegal lengths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_len_q  <= 9'd0;
            in_cnt_q  <= 9'd0;
            discard_q <= 1'b0;
            pat_err_q <= 1'b0;
        end else begin
            pat_err_q <= push && pat_start && len_illegal;
            if (push) begin
                if (pat_start) begin
                    // A zero length still swallows the point that carried it.
                    in_len_q  <= (pt_num == 9'd0) ? 9'd1 : pt_num;
                    in_cnt_q  <= 9'd1;
                    discard_q <= len_illegal;
                end else begin
                    in_cnt_q  <= in_cnt_q + 9'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count carries the extra full bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one point outstanding until its response burst ends.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cv_out_valid) state_d = S_DRAIN;
            S_DRAIN: if (!cv_out_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded controls; cv_out_valid outside WAIT/DRAIN is ignored.
    always_comb begin
        cv_in_valid = (state_q == S_ISSUE);
        pop         = (state_q == S_IDLE) && (count_q != '0);
        drop_sample = (state_q == S_WAIT) && cv_out_valid;
        drain_exit  = (state_q == S_DRAIN) && !cv_out_valid;
        pat_done_d  = drain_exit && ((out_cnt_q + 9'd1) == cv_pt_num_q);
    end

    // Issue registers: loaded on pop, held until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_pt_num_q <= 9'd0;
            cv_in_x_q   <= 10'd0;
            cv_in_y_q   <= 10'd0;
        end else if (pop) begin
            {cv_pt_num_q, cv_in_x_q, cv_in_y_q} <= mem[rd_ptr_q];
        end
    end

    // Count drained responses per pattern and pulse pat_done on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_q  <= 9'd0;
            pat_done_q <= 1'b0;
            drop_q     <= 7'd0;
        end else begin
            pat_done_q <= pat_done_d;
            if (drop_sample) begin
                drop_q <= cv_drop_num;
            end
            if (pat_done_d) begin
                out_cnt_q <= 9'd0;
            end else if (drain_exit) begin
                out_cnt_q <= out_cnt_q + 9'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional per-pattern drop statistics
    // ------------------------------------------------------------------
`ifdef CONVEX_DISPATCH_STATS_EN
    logic [8:0] acc_q;
    logic [8:0] pat_drops_q;

    // Sum the drop count of every response burst; publish with pat_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= 9'd0;
            pat_drops_q <= 9'd0;
        end else begin
            pat_drops_q <= pat_done_d ? acc_q : 9'd0;
            if (pat_done_d) begin
                acc_q <= 9'd0;
            end else if (drop_sample) begin
                acc_q <= acc_q + {2'b00, cv_drop_num};
            end
        end
    end

    assign pat_drops = pat_drops_q;
`else
    assign pat_drops = 9'd0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cv_pt_num = cv_pt_num_q;
    assign cv_in_x   = cv_in_x_q;
    assign cv_in_y   = cv_in_y_q;
    assign pat_done  = pat_done_q;
    assign pat_err   = pat_err_q;
    assign dbg_state = state_q;
    assign dbg_count = count_q;
    assign dbg_drop  = drop_q;

endmodule

// File: tb/tb_convex_dispatch.sv
// tb_convex_dispatch: self-checking bench for convex_dispatch.
// Reference model: a queue of expected issued points built from the input
// patterns (illegal lengths contribute nothing), plus per-pattern issue and
// drop tallies kept by the engine model.

module tb_convex_dispatch;

  localparam int DEPTH = 16;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  pt_num;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic        cv_in_valid;
  logic [8:0]  cv_pt_num;
  logic [9:0]  cv_in_x;
  logic [9:0]  cv_in_y;
  logic        cv_out_valid;
  logic [6:0]  cv_drop_num;
  logic        pat_done;
  logic        pat_err;
  logic [8:0]  pat_drops;
  logic [1:0]  dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;
  logic [6:0]  dbg_drop;

  int n_cmp = 0;
  int n_err = 0;
  logic [28:0] exp_q[$];
  int pat_issued = 0;
  int pat_sum = 0;
  int full_at = -1;
  int px[4];
  int py[4];

  convex_dispatch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .pt_num(pt_num),
    .in_x(in_x), .in_y(in_y),
    .cv_in_valid(cv_in_valid), .cv_pt_num(cv_pt_num),
    .cv_in_x(cv_in_x), .cv_in_y(cv_in_y),
    .cv_out_valid(cv_out_valid), .cv_drop_num(cv_drop_num),
    .pat_done(pat_done), .pat_err(pat_err), .pat_drops(pat_drops),
    .dbg_state(dbg_state), .dbg_count(dbg_count), .dbg_drop(dbg_drop)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // driver: one pattern; only the first point carries the real length
  task automatic send_pattern(input int pt, input bit fixed, input bit gaps);
    int n;
    int t;
    bit legal;
    logic exp_err;
    logic [9:0] x;
    logic [9:0] y;
    n = (pt == 0) ? 1 : pt;
    legal = (pt >= 4) && (pt <= 500);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      x = (fixed && i < 4) ? 10'(px[i]) : 10'($urandom_range(0, 1023));
      y = (fixed && i < 4) ? 10'(py[i]) : 10'($urandom_range(0, 1023));
      in_valid = 1'b1;
      in_x = x;
      in_y = y;
      pt_num = (i == 0) ? 9'(pt) : 9'($urandom_range(0, 511));
      t = 0;
      while (in_ready !== 1'b1 && t < 2000) begin
        if (full_at < 0) full_at = i;
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_ready_timeout: point %0d in_ready=%b, required 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      if (legal) exp_q.push_back({9'(pt), x, y});
      @(negedge clk);
      exp_err = (i == 0) && !legal;
      n_cmp++;
      if (pat_err !== exp_err) begin
        n_err++;
        $display("FAIL pat_err: pt=%0d point %0d got %b, required %b", pt, i, pat_err, exp_err);
      end
    end
    in_valid = 1'b0;
  endtask

  // engine model: answers n issues, checks each against the reference queue
  task automatic run_engine(input int n, input int stall_first, input int def_len,
                            input int def_drop, input int sp_idx, input int sp_len,
                            input int sp_drop);
    logic [28:0] got;
    logic [28:0] exp_e;
    logic [8:0] exp_drops;
    int t;
    int len;
    int drop;
    int d;
    bit last;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (cv_in_valid !== 1'b1 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      n_cmp++;
      if (t >= 3000) begin
        n_err++;
        $display("FAIL issue_timeout: issue %0d got cv_in_valid=%b, required 1", i, cv_in_valid);
        return;
      end
      got = {cv_pt_num, cv_in_x, cv_in_y};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got %h, required no issue", got);
        return;
      end
      exp_e = exp_q.pop_front();
      if (got !== exp_e) begin
        n_err++;
        $display("FAIL issue_data: issue %0d got pt=%0d x=%0d y=%0d, required pt=%0d x=%0d y=%0d",
                 i, got[28:20], got[19:10], got[9:0], exp_e[28:20], exp_e[19:10], exp_e[9:0]);
      end
      len  = (i == sp_idx) ? sp_len : ((def_len > 0) ? def_len : $urandom_range(1, 3));
      drop = (i == sp_idx) ? sp_drop : ((def_drop >= 0) ? def_drop : $urandom_range(0, 3));
      pat_issued++;
      pat_sum += drop;
      last = (pat_issued == int'(exp_e[28:20]));
`ifdef CONVEX_DISPATCH_STATS_EN
      exp_drops = last ? 9'(pat_sum) : 9'd0;
`else
      exp_drops = 9'd0;
`endif
      d = (i == 0) ? stall_first : $urandom_range(0, 2);
      cv_drop_num = 7'($urandom_range(0, 127));
      @(negedge clk);
      n_cmp++;
      if (cv_in_valid !== 1'b0) begin
        n_err++;
        $display("FAIL issue_width: cv_in_valid got %b, required 0", cv_in_valid);
      end
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        n_cmp++;
        if (cv_in_valid !== 1'b0) begin
          n_err++;
          $display("FAIL outstanding: issue while waiting, got %b, required 0", cv_in_valid);
        end
      end
      cv_out_valid = 1'b1;
      cv_drop_num = 7'(drop);
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        n_cmp++;
        if (dbg_state !== ST_DRAIN) begin
          n_err++;
          $display("FAIL drain_state: burst cycle %0d got %0d, required %0d", k, dbg_state, ST_DRAIN);
        end
      end
      cv_out_valid = 1'b0;
      cv_drop_num = 7'($urandom_range(0, 127));
      @(negedge clk);
      n_cmp++;
      if (pat_done !== last) begin
        n_err++;
        $display("FAIL pat_done: issue %0d got %b, required %b", i, pat_done, last);
      end
      n_cmp++;
      if (pat_drops !== exp_drops) begin
        n_err++;
        $display("FAIL pat_drops: issue %0d got %0d, required %0d", i, pat_drops, exp_drops);
      end
      n_cmp++;
      if (cv_in_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
        n_err++;
        $display("FAIL post_drain: got valid=%b state=%0d, required valid=0 state=%0d",
                 cv_in_valid, dbg_state, ST_IDLE);
      end
      n_cmp++;
      if (dbg_drop !== 7'(drop)) begin
        n_err++;
        $display("FAIL sampled_drop: got %0d, required %0d", dbg_drop, drop);
      end
      if (last) begin
        pat_issued = 0;
        pat_sum = 0;
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: %0d points never issued, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cv_in_valid, pat_done, pat_err, pat_drops, cv_pt_num, cv_in_x, cv_in_y} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%b e=%b drops=%0d pt=%0d x=%0d y=%0d, required all 0",
               cv_in_valid, pat_done, pat_err, pat_drops, cv_pt_num, cv_in_x, cv_in_y);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE || dbg_count !== '0) begin
      n_err++;
      $display("FAIL reset_state: got state=%0d count=%0d, required 0/0", dbg_state, dbg_count);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cv_in_valid !== 1'b0 || pat_done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_after_reset: got v=%b d=%b rdy=%b, required 0/0/1",
               cv_in_valid, pat_done, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    send_pattern(4, 1'b0, 1'b0);
    t = 0;
    while (dbg_state !== ST_WAIT && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 50) begin
      n_err++;
      $display("FAIL reach_wait: got state=%0d, required %0d", dbg_state, ST_WAIT);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dbg_state !== ST_IDLE || dbg_count !== '0 || cv_in_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: got state=%0d count=%0d v=%b rdy=%b, required 0/0/0/1",
               dbg_state, dbg_count, cv_in_valid, in_ready);
    end
    @(negedge clk);
    cv_out_valid = 1'b1;
    cv_drop_num = 7'd5;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dbg_state !== ST_IDLE || cv_in_valid !== 1'b0 || pat_done !== 1'b0) begin
        n_err++;
        $display("FAIL stale_burst: cycle %0d got state=%0d v=%b done=%b, required 0/0/0",
                 k, dbg_state, cv_in_valid, pat_done);
      end
    end
    cv_out_valid = 1'b0;
    exp_q.delete();
    pat_issued = 0;
    pat_sum = 0;
    @(negedge clk);
  endtask

  task automatic test_square();
    px = '{0, 10, 10, 0};
    py = '{0, 0, 10, 10};
    fork
      send_pattern(4, 1'b1, 1'b0);
      run_engine(4, 0, 1, 0, -1, 0, 0);
    join
    check_drained("square");
  endtask

  task automatic test_enclose();
    fork
      send_pattern(5, 1'b0, 1'b0);
      run_engine(5, 0, 1, 0, 4, 2, 2);
    join
    check_drained("enclose");
  endtask

  task automatic test_full();
    full_at = -1;
    fork
      send_pattern(20, 1'b0, 1'b0);
      run_engine(20, 40, 0, -1, -1, 0, 0);
    join
    check_drained("full");
    // Empty FIFO, idle FSM, gap-free burst: the first pop overlaps push 2.
    n_cmp++;
    if (full_at != DEPTH + 1) begin
      n_err++;
      $display("FAIL full_point: in_ready fell after %0d pushes, required %0d", full_at, DEPTH + 1);
    end
  endtask

  task automatic test_illegal();
    send_pattern(2, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (cv_in_valid !== 1'b0 || dbg_count !== '0) begin
        n_err++;
        $display("FAIL illegal_discard: got v=%b count=%0d, required 0/0", cv_in_valid, dbg_count);
      end
    end
    fork
      send_pattern(4, 1'b0, 1'b0);
      run_engine(4, 0, 0, -1, -1, 0, 0);
    join
    check_drained("after_illegal");
  endtask

  task automatic test_len_bounds();
    int bad[3];
    bad = '{0, 3, 501};
    for (int b = 0; b < 3; b++) begin
      send_pattern(bad[b], 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (dbg_count !== '0 || dbg_state !== ST_IDLE) begin
        n_err++;
        $display("FAIL bound_discard: pt=%0d got count=%0d state=%0d, required 0/0",
                 bad[b], dbg_count, dbg_state);
      end
    end
    fork
      send_pattern(500, 1'b0, 1'b1);
      run_engine(500, 0, 1, 0, 499, 3, 9);
    join
    check_drained("len500");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_pattern(4, 1'b0, 1'b0);
        send_pattern(6, 1'b0, 1'b0);
      end
      run_engine(10, 0, 0, -1, -1, 0, 0);
    join
    check_drained("back_to_back");
  endtask

  task automatic test_random();
    int pts[8];
    int total;
    total = 0;
    for (int k = 0; k < 8; k++) begin
      pts[k] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 9);
      if (pts[k] >= 4) total += pts[k];
    end
    fork
      begin
        for (int k = 0; k < 8; k++) send_pattern(pts[k], 1'b0, 1'b1);
      end
      run_engine(total, 0, 0, -1, -1, 0, 0);
    join
    check_drained("random");
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    pt_num = 9'd0;
    in_x = 10'd0;
    in_y = 10'd0;
    cv_out_valid = 1'b0;
    cv_drop_num = 7'd0;
    @(negedge clk);
    test_reset();
    test_reset_mid();
    test_square();
    test_enclose();
    test_full();
    test_illegal();
    test_back_to_back();
    test_random();
    test_len_bounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/convex_dispatch.md
# convex_dispatch

Upstream feeder for the convex-hull engine. Accepts a pattern's points as a back-to-back burst, buffers them in a FIFO, and issues them to the hull engine one point at a time. Before issuing the next point, it waits for the engine's complete response burst (`out_valid` high for 1 or `drop_num` cycles). It also reports per-pattern completion.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries. Power of two, ≥ 4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream point valid.
- `in_ready`  out  1  FIFO can accept. Combinational: `count < DEPTH`.
- `pt_num`  in  9  pattern length. Sampled only with the first accepted point of a pattern.
- `in_x`, `in_y`  in  10 each  point coordinates.
- `cv_in_valid`  out  1  one-cycle issue pulse to the engine.
- `cv_pt_num`  out  9  pattern length of the issued point.
- `cv_in_x`, `cv_in_y`  out  10 each  issued point.
- `cv_out_valid`  in  1  engine response valid.
- `cv_drop_num`  in  7  engine drop count. Stable for the whole burst.
- `pat_done`  out  1  one-cycle pulse after the last point's response burst ends.
- `pat_err`  out  1  one-cycle pulse when an illegal `pt_num` is sampled.
- `pat_drops`  out  9  per-pattern drop total. Valid with `pat_done`. See Configuration.

## Operation
- **Input side:** push when `in_valid && in_ready`.
  - On the first push of a pattern, latch `pt_num` into `in_len` and set `in_cnt = 1`. On later pushes, increment `in_cnt`.
  - When `in_cnt == in_len`, the next push starts a new pattern.
  - Each FIFO entry is 29 bits: {`pt_num`, x, y}.
- **Illegal length:** a sampled `pt_num < 4` or `> 500` pulses `pat_err` (registered, next cycle).
  - That point and the following `max(pt_num,1) - 1` points are accepted (`in_ready` high) but not written to the FIFO.
- **FIFO:** read/write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. `count` is `log2(DEPTH)+1` bits.
  - A simultaneous push and pop keeps `count` unchanged.
  - Push is never allowed while full.
  - Pop only from `S_IDLE` when `count != 0`.
- **Dispatch FSM:** `S_IDLE`, `S_ISSUE`, `S_WAIT`, `S_DRAIN`.
  - `S_IDLE` → `S_ISSUE` when the FIFO is non-empty. The head is popped into output registers.
  - `S_ISSUE`: `cv_in_valid = 1` for exactly this cycle; the `cv_*` data registers hold the point. Next state is `S_WAIT`.
  - `S_WAIT` → `S_DRAIN` on the first cycle with `cv_out_valid = 1`. That cycle's `cv_drop_num` is sampled.
  - `S_DRAIN` stays while `cv_out_valid = 1`. On the first cycle with `cv_out_valid = 0`, go to `S_IDLE`, increment `out_cnt`, and pulse `pat_done` if `out_cnt + 1 == cv_pt_num`. `out_cnt` clears on `pat_done`.
- `cv_in_x`, `cv_in_y` and `cv_pt_num` hold their last issued value outside `S_ISSUE`.
- **Reset values:** all outputs 0, FIFO empty, FSM in `S_IDLE`, all counters 0.
- **Reset mid-operation:** everything clears immediately. Any engine burst still in flight is ignored; the FSM is back in `S_IDLE` and the FIFO is empty.

## Timing
- Issue latency: a point written into an empty FIFO with the FSM in `S_IDLE` at edge N is popped at N+1. `cv_in_valid` is high in the cycle after N+1.
- Exactly one outstanding point at a time. The next `cv_in_valid` comes no earlier than 2 cycles after `cv_out_valid` falls (one `S_DRAIN` exit cycle plus one `S_IDLE` cycle). This guarantees the engine has returned to idle.
- `pat_done` and `pat_drops` are registered and asserted in the `S_IDLE` cycle that follows the drain.
- `cv_out_valid` while in `S_IDLE` or `S_ISSUE` is ignored (spurious).
- Upstream may burst at 1 point/cycle until the FIFO is full. `in_ready` reflects the current count only. A pop in the same cycle does not raise `in_ready` combinationally.

## Configuration
- Macro: `CONVEX_DISPATCH_STATS_EN`.
- **Defined:** a 9-bit accumulator adds each sampled `cv_drop_num` for the current pattern.
  - `pat_drops` presents the total with `pat_done`, then returns to 0 the next cycle.
  - The accumulator clears on `pat_done`. The sum is at most 497, so there is no overflow.
- **Undefined:** no accumulator; `pat_drops` is tied to 0.

## Test plan
1. Reset with no traffic: all outputs 0 and `in_ready = 1`. Assert `rst_n = 0` during `S_WAIT`: the FSM returns to `S_IDLE`, `count = 0`, and `cv_in_valid` stays low.
2. 4-point square (0,0), (10,0), (10,10), (0,10) with `pt_num = 4`:
   - Exactly 4 `cv_in_valid` pulses with `cv_pt_num = 4`.
   - Model engine responds with 1-cycle bursts with `drop_num = 0`.
   - `pat_done` pulses once after the 4th drain; `pat_drops = 0`.
3. 5-point pattern where the 5th point encloses 2 prior points:
   - Engine holds `cv_out_valid` 2 cycles with `drop_num = 2`.
   - The FSM stays in `S_DRAIN` for 2 cycles; the next issue comes ≥ 2 cycles after the fall.
   - `pat_drops = 2` (STATS_EN build).
4. Burst of 20 points with `DEPTH = 16` and a stalled engine:
   - `in_ready` drops after 16 pushes, or 17 if the first pop overlaps.
   - No entry is lost; the issue order matches the input order.
5. `pt_num = 2`: `pat_err` pulses, 2 points are accepted and discarded, and there is no `cv_in_valid`. A following legal `pt_num = 4` pattern is dispatched normally.
6. Back-to-back patterns with `pt_num = 4` then `pt_num = 6`:
   - `cv_pt_num` switches exactly at the 5th issue.
   - `pat_done` pulses twice; `out_cnt` clears between them.
